// File: rtl/conv_window_mac_pkg.sv
// Shared definitions for the windowed convolution MAC: FSM states,
// parameter derivations and the result clip helper.
package conv_window_mac_pkg;

    // Widest intermediate result the clip helper can inspect.
    localparam int unsigned SAT_MAX_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_MAC,
        ST_OUT
    } state_t;

    function automatic int calc_ntap(input int ksize);
        return ksize * ksize;
    endfunction

    function automatic int calc_passes(input int ntap, input int lanes);
        return (ntap + lanes - 1) / lanes;
    endfunction

    function automatic int calc_acc_w(input int data_w, input int ntap);
        return 2 * data_w + $clog2(ntap);
    endfunction

    // Returns {above_max, below_min} of r against a signed data_w-bit range.
    function automatic logic [1:0] clip_flags(input logic signed [SAT_MAX_W-1:0] r,
                                              input int data_w);
        logic signed [SAT_MAX_W-1:0] hi;
        hi = signed'((SAT_MAX_W'(1) << (data_w - 1)) - SAT_MAX_W'(1));
        return {r > hi, r < ~hi};
    endfunction

endpackage

// File: rtl/conv_mac_lane_sum.sv
// Combinational LANES-wide signed multiply and sum into one accumulator-width partial.
module conv_mac_lane_sum #(
    parameter int DATA_W = 16,
    parameter int LANES  = 3,
    parameter int ACC_W  = 36
) (
    input  logic [LANES*DATA_W-1:0] w_lane,
    input  logic [LANES*DATA_W-1:0] x_lane,
    output logic signed [ACC_W-1:0] partial_sum
);

    logic signed [DATA_W-1:0]   a;
    logic signed [DATA_W-1:0]   b;
    logic signed [2*DATA_W-1:0] prod;

    // Multiply each lane pair and sum the sign-extended products.
    always_comb begin
        partial_sum = '0;
        a           = '0;
        b           = '0;
        prod        = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            a           = signed'(w_lane[j*DATA_W +: DATA_W]);
            b           = signed'(x_lane[j*DATA_W +: DATA_W]);
            prod        = (2*DATA_W)'(a) * (2*DATA_W)'(b);
            partial_sum = partial_sum + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// KSIZE x KSIZE signed window dot product, LANES taps per MAC cycle,
// arithmetic-shift scaling and saturate/truncate output with valid/ready handshake.
module conv_window_mac
    import conv_window_mac_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int KSIZE     = 3,
    parameter int LANES     = 3,
    parameter int ACC_W     = calc_acc_w(DATA_W, KSIZE * KSIZE),
    parameter int OUT_SHIFT = 0,
    localparam int NTAP     = KSIZE * KSIZE,
    localparam int AW       = (NTAP > 1) ? $clog2(NTAP) : 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_err,
    input  logic              sat_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              busy
);

    localparam int P                    = calc_passes(NTAP, LANES);
    localparam int CW                   = $clog2(P + 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NTAP - 1);
    localparam logic [CW-1:0] LAST_CYC  = CW'(P);
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                      state, state_n;
    logic signed [DATA_W-1:0]    w_mem [NTAP];
    logic signed [DATA_W-1:0]    x_mem [NTAP];
    logic [AW-1:0]               idx;
    logic [CW-1:0]               cyc;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     partial;
    logic                        sat_en_q;
    logic [LANES*DATA_W-1:0]     w_lane;
    logic [LANES*DATA_W-1:0]     x_lane;
    logic                        accept;
    logic                        cfg_ok;
    int                          tap;
    logic signed [SAT_MAX_W-1:0] r_wide;
    logic [1:0]                  flags;
    logic [DATA_W-1:0]           res_data;

    assign in_ready  = (state == ST_IDLE) || (state == ST_COLLECT);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign cfg_ok    = cfg_we && (state == ST_IDLE) && (int'(cfg_addr) < NTAP);

    // Route the taps of the current MAC cycle onto the lanes; taps past NTAP read as zero.
    always_comb begin
        w_lane = '0;
        x_lane = '0;
        tap    = 0;
        for (int unsigned j = 0; j < LANES; j++) begin
            tap = int'(cyc) * LANES + int'(j);
            if (tap < NTAP) begin
                w_lane[j*DATA_W +: DATA_W] = w_mem[AW'(tap)];
                x_lane[j*DATA_W +: DATA_W] = x_mem[AW'(tap)];
            end
        end
    end

    conv_mac_lane_sum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_lane_sum (
        .w_lane      (w_lane),
        .x_lane      (x_lane),
        .partial_sum (partial)
    );

    // Scale the finished accumulator and apply saturation or truncation.
    always_comb begin
        r_wide   = SAT_MAX_W'(acc) >>> OUT_SHIFT;
        flags    = clip_flags(r_wide, DATA_W);
        res_data = r_wide[DATA_W-1:0];
        if (sat_en_q) begin
            if (flags[1]) begin
                res_data = POS_MAX;
            end else if (flags[0]) begin
                res_data = NEG_MIN;
            end
        end
    end

    // Next-state logic; the last pixel of a window always enters MAC (covers NTAP==1 from IDLE).
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_COLLECT: if (accept) state_n = (idx == LAST_IDX) ? ST_MAC : ST_COLLECT;
            ST_MAC:              if (cyc == LAST_CYC) state_n = ST_OUT;
            ST_OUT:              if (out_ready) state_n = ST_IDLE;
            default:             state_n = ST_IDLE;
        endcase
    end

    // State register, weight/pixel buffers, accumulator and registered output.
    // MAC runs P accumulate cycles (cyc 0..P-1) then one cycle (cyc==P) registering the result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            for (int unsigned i = 0; i < NTAP; i++) begin
                w_mem[i] <= '0;
                x_mem[i] <= '0;
            end
            idx      <= '0;
            cyc      <= '0;
            acc      <= '0;
            sat_en_q <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state   <= state_n;
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_ok) begin
                w_mem[cfg_addr] <= cfg_wdata;
            end
            if (accept) begin
                x_mem[idx] <= in_data;
                if (idx == LAST_IDX) begin
                    idx      <= '0;
                    cyc      <= '0;
                    acc      <= '0;
                    sat_en_q <= sat_en;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (state == ST_MAC) begin
                if (cyc == LAST_CYC) begin
                    out_data <= res_data;
                    out_sat  <= |flags;
                end else begin
                    acc <= acc + partial;
                    cyc <= cyc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: three builds (LANES=3,1,9) driven with identical stimulus.
module tb_conv_window_mac;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [15:0]      cfg_wdata;
    logic             sat_en;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             out_ready;
    logic [2:0]       cfg_err;
    logic [2:0]       in_ready;
    logic [2:0]       out_valid;
    logic [2:0]       out_sat;
    logic [2:0]       busy;
    logic [2:0][15:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int lat[3];
    int exp_lat[3] = '{4, 10, 2};
    logic [2:0] ce_seen;
    logic [2:0] ce_after;
    logic       missed;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv_window_mac #(
            .DATA_W    (16),
            .KSIZE     (3),
            .LANES     ((g == 0) ? 3 : (g == 1) ? 1 : 9),
            .OUT_SHIFT (0)
        ) u_dut (
            .Clk       (Clk),
            .Rst       (Rst),
            .cfg_we    (cfg_we),
            .cfg_addr  (cfg_addr),
            .cfg_wdata (cfg_wdata),
            .cfg_err   (cfg_err[g]),
            .sat_en    (sat_en),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .in_data   (in_data),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_data  (out_data[g]),
            .out_sat   (out_sat[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_weights(input logic [15:0] v);
        for (int i = 0; i < 9; i++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 4'(i);
            cfg_wdata = v;
            tick();
        end
        cfg_we = 1'b0;
    endtask

    // Streams one window back to back; optionally writes weight 0 alongside pixel cfg_at.
    task automatic feed_window(input logic [15:0] px[9], input int cfg_at, input logic [15:0] cfg_val);
        missed = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = px[i];
            if (in_ready !== 3'b111) missed = 1'b1;
            if (i == cfg_at) begin
                cfg_we    = 1'b1;
                cfg_addr  = 4'd0;
                cfg_wdata = cfg_val;
            end
            tick();
            cfg_we = 1'b0;
            if (i == cfg_at) ce_seen = cfg_err;
            if (i == cfg_at + 1) ce_after = cfg_err;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        lat = '{0, 0, 0};
        for (int k = 1; k <= 14; k++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (out_valid[d] === 1'b1 && lat[d] == 0) lat[d] = k;
            end
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        n_checks++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 000", out_valid); end
        n_checks++; if (out_data !== 48'h0) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
        n_checks++; if (out_sat !== 3'b000) begin n_fail++; $display("FAIL reset_out_sat: got %b, expected 000", out_sat); end
        n_checks++; if (cfg_err !== 3'b000) begin n_fail++; $display("FAIL reset_cfg_err: got %b, expected 000", cfg_err); end
        n_checks++; if (busy !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b, expected 000", busy); end
        tick();
        n_checks++; if (in_ready !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 111", in_ready); end
    endtask

    task automatic test_sum();
        logic [15:0] px[9];
        for (int i = 0; i < 9; i++) px[i] = 16'(i + 1);
        load_weights(16'd1);
        sat_en = 1'b1;
        feed_window(px, -1, 16'd0);
        n_checks++; if (missed !== 1'b0) begin n_fail++; $display("FAIL sum_in_ready: got missed=%b, expected 0", missed); end
        wait_out();
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (lat[d] !== exp_lat[d]) begin n_fail++; $display("FAIL sum_latency dut%0d: got %0d, expected %0d", d, lat[d], exp_lat[d]); end
            n_checks++; if (out_data[d] !== 16'd45) begin n_fail++; $display("FAIL sum_data dut%0d: got %h, expected 002d", d, out_data[d]); end
            n_checks++; if (out_sat[d] !== 1'b0) begin n_fail++; $display("FAIL sum_sat dut%0d: got %b, expected 0", d, out_sat[d]); end
        end
        accept_out();
        n_checks++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL sum_accept_valid: got %b, expected 000", out_valid); end
    endtask

    task automatic test_negative();
        logic [15:0] px[9];
        for (int i = 0; i < 9; i++) px[i] = 16'd2;
        load_weights(16'hFFFF);
        sat_en = 1'b1;
        feed_window(px, -1, 16'd0);
        wait_out();
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (lat[d] !== exp_lat[d]) begin n_fail++; $display("FAIL neg_latency dut%0d: got %0d, expected %0d", d, lat[d], exp_lat[d]); end
            n_checks++; if (out_data[d] !== 16'hFFEE) begin n_fail++; $display("FAIL neg_data dut%0d: got %h, expected ffee", d, out_data[d]); end
            n_checks++; if (out_sat[d] !== 1'b0) begin n_fail++; $display("FAIL neg_sat dut%0d: got %b, expected 0", d, out_sat[d]); end
        end
        accept_out();
    endtask

    task automatic test_saturate();
        logic [15:0] px[9];
        for (int i = 0; i < 9; i++) px[i] = 16'h7FFF;
        load_weights(16'h7FFF);
        sat_en = 1'b1;
        feed_window(px, -1, 16'd0);
        wait_out();
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (out_data[d] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_on_data dut%0d: got %h, expected 7fff", d, out_data[d]); end
            n_checks++; if (out_sat[d] !== 1'b1) begin n_fail++; $display("FAIL sat_on_flag dut%0d: got %b, expected 1", d, out_sat[d]); end
        end
        accept_out();
        // sat_en changes after the last pixel must not affect this window
        sat_en = 1'b0;
        feed_window(px, -1, 16'd0);
        sat_en = 1'b1;
        wait_out();
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (out_data[d] !== 16'h0009) begin n_fail++; $display("FAIL sat_off_data dut%0d: got %h, expected 0009", d, out_data[d]); end
            n_checks++; if (out_sat[d] !== 1'b1) begin n_fail++; $display("FAIL sat_off_flag dut%0d: got %b, expected 1", d, out_sat[d]); end
        end
        accept_out();
    endtask

    task automatic test_back_to_back();
        logic [15:0] px[9];
        for (int i = 0; i < 9; i++) px[i] = 16'(i + 1);
        load_weights(16'd1);
        sat_en = 1'b1;
        feed_window(px, -1, 16'd0);
        wait_out();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (out_data !== {3{16'd45}}) begin n_fail++; $display("FAIL hold_data cycle%0d: got %h, expected 002d x3", c, out_data); end
            n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL hold_in_ready cycle%0d: got %b, expected 000", c, in_ready); end
            n_checks++; if (busy !== 3'b111) begin n_fail++; $display("FAIL hold_busy cycle%0d: got %b, expected 111", c, busy); end
            n_checks++; if (out_valid !== 3'b111) begin n_fail++; $display("FAIL hold_valid cycle%0d: got %b, expected 111", c, out_valid); end
        end
        accept_out();
        n_checks++; if (out_valid !== 3'b000) begin n_fail++; $display("FAIL b2b_valid: got %b, expected 000", out_valid); end
        n_checks++; if (in_ready !== 3'b111) begin n_fail++; $display("FAIL b2b_in_ready: got %b, expected 111", in_ready); end
        for (int i = 0; i < 9; i++) px[i] = 16'd2;
        feed_window(px, -1, 16'd0);
        n_checks++; if (missed !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got missed=%b, expected 0", missed); end
        wait_out();
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (lat[d] !== exp_lat[d]) begin n_fail++; $display("FAIL b2b_latency dut%0d: got %0d, expected %0d", d, lat[d], exp_lat[d]); end
            n_checks++; if (out_data[d] !== 16'd18) begin n_fail++; $display("FAIL b2b_data dut%0d: got %h, expected 0012", d, out_data[d]); end
        end
        accept_out();
    endtask

    task automatic test_cfg_errors();
        logic [15:0] px[9];
        for (int i = 0; i < 9; i++) px[i] = 16'(i + 1);
        load_weights(16'd1);
        sat_en = 1'b1;
        // Write alongside the first pixel: still IDLE, so w0 becomes 2
        feed_window(px, 0, 16'd2);
        n_checks++; if (ce_seen !== 3'b000) begin n_fail++; $display("FAIL cfg_first_pixel_err: got %b, expected 000", ce_seen); end
        wait_out();
        n_checks++; if (out_data !== {3{16'd46}}) begin n_fail++; $display("FAIL cfg_first_pixel_data: got %h, expected 002e x3", out_data); end
        accept_out();
        // Write during COLLECT is dropped
        feed_window(px, 4, 16'd100);
        n_checks++; if (ce_seen !== 3'b111) begin n_fail++; $display("FAIL cfg_collect_err: got %b, expected 111", ce_seen); end
        n_checks++; if (ce_after !== 3'b000) begin n_fail++; $display("FAIL cfg_collect_pulse: got %b, expected 000", ce_after); end
        wait_out();
        n_checks++; if (out_data !== {3{16'd46}}) begin n_fail++; $display("FAIL cfg_collect_data: got %h, expected 002e x3", out_data); end
        accept_out();
        cfg_we    = 1'b1;
        cfg_addr  = 4'd9;
        cfg_wdata = 16'd5;
        tick();
        cfg_we = 1'b0;
        n_checks++; if (cfg_err !== 3'b111) begin n_fail++; $display("FAIL cfg_addr9_err: got %b, expected 111", cfg_err); end
        tick();
        n_checks++; if (cfg_err !== 3'b000) begin n_fail++; $display("FAIL cfg_addr9_pulse: got %b, expected 000", cfg_err); end
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] px[9];
        logic        saw_valid;
        for (int i = 0; i < 9; i++) px[i] = 16'(i + 1);
        load_weights(16'd1);
        sat_en = 1'b1;
        feed_window(px, -1, 16'd0);
        n_checks++; if (busy !== 3'b111) begin n_fail++; $display("FAIL rst_mac_busy_before: got %b, expected 111", busy); end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        n_checks++; if (busy !== 3'b000) begin n_fail++; $display("FAIL rst_mac_busy_after: got %b, expected 000", busy); end
        n_checks++; if (in_ready !== 3'b111) begin n_fail++; $display("FAIL rst_mac_in_ready: got %b, expected 111", in_ready); end
        saw_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid !== 3'b000) saw_valid = 1'b1;
            tick();
        end
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mac_no_valid: got %b, expected 0", saw_valid); end
        feed_window(px, -1, 16'd0);
        wait_out();
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (lat[d] !== exp_lat[d]) begin n_fail++; $display("FAIL rst_zero_latency dut%0d: got %0d, expected %0d", d, lat[d], exp_lat[d]); end
            n_checks++; if (out_data[d] !== 16'd0) begin n_fail++; $display("FAIL rst_zero_data dut%0d: got %h, expected 0000", d, out_data[d]); end
        end
        accept_out();
    endtask

    initial begin
        Rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        sat_en    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ce_seen   = '0;
        ce_after  = '0;
        missed    = 1'b0;
        test_reset();
        test_sum();
        test_negative();
        test_saturate();
        test_back_to_back();
        test_cfg_errors();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
